// File: rtl/imm_prefix_sequencer_pkg.sv
// imm_prefix_sequencer_pkg: extension codes, instruction field positions and sequencer state encodings
package imm_prefix_sequencer_pkg;
  localparam logic [1:0] EXT16 = 2'd0;
  localparam logic [1:0] EXT17 = 2'd1;
  localparam logic [1:0] EXT22 = 2'd2;
  localparam logic [1:0] EXT23 = 2'd3;
  localparam int CLS_HI = 31;
  localparam int CLS_LO = 30;
  localparam int PFX_W = 9;
  localparam logic [0:0] IPS_IDLE = 1'b0;
  localparam logic [0:0] IPS_PREFIXED = 1'b1;
endpackage

// File: rtl/imm_prefix_sequencer_sign_extend.sv
// imm_prefix_sequencer_sign_extend: sign-extends imm_i to 32 bits from bit 15/16/21/22 chosen by msb (EXT16/17/22/23)
module imm_prefix_sequencer_sign_extend
  import imm_prefix_sequencer_pkg::*;
(
  input  logic [1:0]  msb,
  input  logic [22:0] imm_i,
  output logic [31:0] imm_o
);
  always_comb
    imm_o = msb == EXT16 ? {{16{imm_i[15]}}, imm_i[15:0]} :
            msb == EXT17 ? {{15{imm_i[16]}}, imm_i[16:0]} :
            msb == EXT22 ? {{10{imm_i[21]}}, imm_i[21:0]} :
                           {{9{imm_i[22]}}, imm_i[22:0]};
endmodule

// File: rtl/imm_prefix_sequencer.sv
// imm_prefix_sequencer: classifies instr_i, merges IMM prefixes into a 32-bit immediate, registers valid_o/imm_o/ext_sel_o/prefixed_o/prefix_pending_o/prefix_drop_o under stall_i/flush_i
module imm_prefix_sequencer
  import imm_prefix_sequencer_pkg::*;
#(
  parameter logic [4:0] PREFIX_OPC = 5'h1F,
  parameter int MAX_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] imm_o,
  output logic [1:0]  ext_sel_o,
  output logic        prefixed_o,
  output logic        prefix_pending_o,
  output logic        prefix_drop_o
);
  localparam int CW = MAX_GAP == 0 ? 1 : $clog2(MAX_GAP + 1);
  localparam logic [CW-1:0] GAP_LIM = CW'(MAX_GAP);
  logic [0:0] state;
  logic [PFX_W-1:0] upper;
  logic [CW-1:0] gap;
  logic [CW-1:0] gap_nxt;
  logic [1:0] cls;
  logic is_prefix;
  logic [31:0] sext;
  logic unused;
  assign unused = ^instr_i[26:23];
  assign cls = instr_i[CLS_HI:CLS_LO];
  assign is_prefix = instr_i[31:27] == PREFIX_OPC;
  assign gap_nxt = gap + 1'b1;
  assign prefix_pending_o = state == IPS_PREFIXED;
  imm_prefix_sequencer_sign_extend u_sext (
    .msb  (cls),
    .imm_i(instr_i[22:0]),
    .imm_o(sext)
  );
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state <= IPS_IDLE;
      upper <= '0;
      gap <= '0;
      valid_o <= 1'b0;
      imm_o <= '0;
      ext_sel_o <= EXT16;
      prefixed_o <= 1'b0;
      prefix_drop_o <= 1'b0;
    end else if (stall_i) begin
      prefix_drop_o <= 1'b0;
    end else begin
      prefix_drop_o <= 1'b0;
      if (valid_i && is_prefix) begin
        upper <= instr_i[PFX_W-1:0];
        state <= IPS_PREFIXED;
        gap <= '0;
        valid_o <= 1'b0;
      end else if (valid_i) begin
        valid_o <= 1'b1;
        ext_sel_o <= cls;
        imm_o <= state == IPS_PREFIXED ? {upper, instr_i[22:0]} : sext;
        prefixed_o <= state == IPS_PREFIXED;
        state <= IPS_IDLE;
      end else begin
        valid_o <= 1'b0;
        if (state == IPS_PREFIXED && MAX_GAP != 0) begin
          gap <= gap_nxt == GAP_LIM ? '0 : gap_nxt;
          state <= gap_nxt == GAP_LIM ? IPS_IDLE : IPS_PREFIXED;
          prefix_drop_o <= gap_nxt == GAP_LIM;
        end
      end
    end
  end
endmodule

// File: tb/tb_imm_prefix_sequencer.sv
// tb_imm_prefix_sequencer: directed plan plus randomized traffic against a spec-level reference model
module tb_imm_prefix_sequencer;
  localparam int MG = 4;
  logic clk = 1'b0;
  logic rst, stall_i, flush_i, valid_i;
  logic [31:0] instr_i;
  logic valid_o, prefixed_o, prefix_pending_o, prefix_drop_o;
  logic [31:0] imm_o;
  logic [1:0] ext_sel_o;
  int n_chk = 0;
  int n_fail = 0;
  bit m_pend, m_valid, m_pfx, m_drop;
  logic [8:0] m_upper;
  logic [31:0] m_imm;
  logic [1:0] m_ext;
  int m_gap;
  imm_prefix_sequencer #(.PREFIX_OPC(5'h1F), .MAX_GAP(MG)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .instr_i(instr_i), .valid_o(valid_o), .imm_o(imm_o), .ext_sel_o(ext_sel_o),
    .prefixed_o(prefixed_o), .prefix_pending_o(prefix_pending_o), .prefix_drop_o(prefix_drop_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] sext_model(input logic [31:0] ins);
    int w;
    longint v;
    w = ins[31:30] == 2'd0 ? 16 : ins[31:30] == 2'd1 ? 17 : ins[31:30] == 2'd2 ? 22 : 23;
    v = longint'(ins) & ((longint'(1) << w) - 1);
    if (((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
    return v[31:0];
  endfunction
  task automatic model_edge();
    if (rst || flush_i) begin
      m_pend = 0; m_upper = '0; m_gap = 0; m_valid = 0; m_imm = '0; m_ext = 2'd0; m_pfx = 0; m_drop = 0;
    end else if (stall_i) begin
      m_drop = 0;
    end else begin
      m_drop = 0;
      if (valid_i && instr_i[31:27] == 5'h1F) begin
        m_upper = instr_i[8:0]; m_pend = 1; m_gap = 0; m_valid = 0;
      end else if (valid_i) begin
        m_valid = 1;
        m_ext = instr_i[31:30];
        m_pfx = m_pend;
        m_imm = m_pend ? {m_upper, instr_i[22:0]} : sext_model(instr_i);
        m_pend = 0;
      end else begin
        m_valid = 0;
        if (m_pend && MG != 0) begin
          m_gap++;
          if (m_gap == MG) begin
            m_pend = 0; m_gap = 0; m_drop = 1;
          end
        end
      end
    end
  endtask
  task automatic step(input bit r, input bit f, input bit s, input bit v, input logic [31:0] ins);
    rst = r; flush_i = f; stall_i = s; valid_i = v; instr_i = ins;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid_o", {31'b0, valid_o}, {31'b0, m_valid});
    chk("prefix_pending_o", {31'b0, prefix_pending_o}, {31'b0, m_pend});
    chk("prefix_drop_o", {31'b0, prefix_drop_o}, {31'b0, m_drop});
    chk("imm_o", imm_o, m_imm);
    chk("ext_sel_o", {30'b0, ext_sel_o}, {30'b0, m_ext});
    chk("prefixed_o", {31'b0, prefixed_o}, {31'b0, m_pfx});
  endtask
  initial begin
    logic [31:0] ins;
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h12345678);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_imm", imm_o, 32'h0);
    chk("rst_pend", {31'b0, prefix_pending_o}, 32'd0);
    step(0, 0, 0, 1, 32'h00008001);
    chk("alu_imm", imm_o, 32'hFFFF8001);
    chk("alu_ext", {30'b0, ext_sel_o}, 32'd0);
    chk("alu_valid", {31'b0, valid_o}, 32'd1);
    step(0, 0, 0, 1, 32'h4000FFFF);
    chk("ls_imm", imm_o, 32'h0000FFFF);
    chk("ls_ext", {30'b0, ext_sel_o}, 32'd1);
    step(0, 0, 0, 1, 32'hF80001AB);
    chk("pfx_valid", {31'b0, valid_o}, 32'd0);
    chk("pfx_pend", {31'b0, prefix_pending_o}, 32'd1);
    step(0, 0, 0, 1, 32'h807FFFFF);
    chk("merge_imm", imm_o, 32'hD5FFFFFF);
    chk("merge_pfx", {31'b0, prefixed_o}, 32'd1);
    chk("merge_ext", {30'b0, ext_sel_o}, 32'd2);
    chk("merge_pend", {31'b0, prefix_pending_o}, 32'd0);
    step(0, 0, 0, 1, 32'hF80001AB);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 32'h0);
      chk("gap_nodrop", {31'b0, prefix_drop_o}, 32'd0);
    end
    step(0, 0, 0, 0, 32'h0);
    chk("timeout_drop", {31'b0, prefix_drop_o}, 32'd1);
    chk("timeout_pend", {31'b0, prefix_pending_o}, 32'd0);
    step(0, 0, 0, 0, 32'h0);
    chk("drop_pulse", {31'b0, prefix_drop_o}, 32'd0);
    step(0, 0, 0, 1, 32'h00008001);
    chk("after_to_imm", imm_o, 32'hFFFF8001);
    chk("after_to_pfx", {31'b0, prefixed_o}, 32'd0);
    step(0, 0, 0, 1, 32'hF80001AB);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h0);
    chk("stall_pend", {31'b0, prefix_pending_o}, 32'd1);
    chk("stall_imm", imm_o, 32'hFFFF8001);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0);
    chk("stall_gap_frozen", {31'b0, prefix_pending_o}, 32'd1);
    step(0, 1, 1, 0, 32'h0);
    chk("flush_pend", {31'b0, prefix_pending_o}, 32'd0);
    chk("flush_imm", imm_o, 32'h0);
    chk("flush_drop", {31'b0, prefix_drop_o}, 32'd0);
    step(0, 0, 0, 0, 32'h0);
    chk("flush_silent", {31'b0, prefix_drop_o}, 32'd0);
    step(0, 0, 0, 1, 32'h00008001);
    step(0, 0, 0, 1, 32'hF80001AB);
    step(1, 0, 0, 1, 32'h00008001);
    chk("rst_mid_imm", imm_o, 32'h0);
    chk("rst_mid_pend", {31'b0, prefix_pending_o}, 32'd0);
    step(0, 0, 0, 1, 32'h807FFFFF);
    chk("post_rst_imm", imm_o, 32'hFFFFFFFF);
    chk("post_rst_ext", {30'b0, ext_sel_o}, 32'd2);
    chk("post_rst_pfx", {31'b0, prefixed_o}, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:27] = 5'h1F;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 55, ins);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
